// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: EX-stage ALU with iterative multiply/divide and a valid/ready
// handshake on both sides.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   flush       abort any op in flight; a pending result is dropped
//   in_valid    request valid           in_ready  unit idle, can accept
//   alu_op      5-bit operation code
//   alu_src0    operand A / dividend / multiplicand
//   alu_src1    operand B / divisor / multiplier / shift amount
//   out_valid   alu_res valid           out_ready consumer takes the result
//   alu_res     result                  busy      state != IDLE
//
// Single-cycle ops land in DONE on the accept edge. MUL* and DIV*/REM* run
// DATA_W shift-add / restoring iterations on operand magnitudes; the last
// iteration also applies the sign fix and writes alu_res.
module alu_mdu_iter #(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_src0,
  input  logic [DATA_W-1:0] alu_src1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_res,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_SLT   = 5'b00100;
  localparam logic [4:0] OP_SLTU  = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b01001;
  localparam logic [4:0] OP_OR    = 5'b01010;
  localparam logic [4:0] OP_XOR   = 5'b01011;
  localparam logic [4:0] OP_SLL   = 5'b01110;
  localparam logic [4:0] OP_SRL   = 5'b01111;
  localparam logic [4:0] OP_SRA   = 5'b10000;
  localparam logic [4:0] OP_SRC0  = 5'b10001;
  localparam logic [4:0] OP_SRC1  = 5'b10010;
  localparam logic [4:0] OP_MUL   = 5'b10011;
  localparam logic [4:0] OP_MULH  = 5'b10100;
  localparam logic [4:0] OP_MULHU = 5'b10101;
  localparam logic [4:0] OP_DIV   = 5'b10110;
  localparam logic [4:0] OP_DIVU  = 5'b10111;
  localparam logic [4:0] OP_REM   = 5'b11000;
  localparam logic [4:0] OP_REMU  = 5'b11001;

  localparam logic [SH_W-1:0]   CNT_LAST = SH_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] f_alu(input logic [4:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [SH_W-1:0] sh;
    sa = a;
    sb = b;
    sh = b[SH_W-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {{(DATA_W-1){1'b0}}, (sa < sb)};
      OP_SLTU: return {{(DATA_W-1){1'b0}}, (a < b)};
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return sa >>> sh;
      OP_SRC0: return a;
      OP_SRC1: return b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] f_sign_fix(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] f_sign_fix_wide(input logic [2*DATA_W-1:0] v,
                                                          input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]        state;
  logic [4:0]        op_q;
  logic              neg_q;    // product / quotient sign
  logic              neg_r;    // remainder sign (dividend's)
  logic [DATA_W-1:0] acc_hi;   // product high half / partial remainder
  logic [DATA_W-1:0] acc_lo;   // multiplier shifting out / dividend-quotient
  logic [DATA_W-1:0] mcand;    // multiplicand or divisor magnitude
  logic [SH_W-1:0]   cnt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Accept-side decode
  logic              is_mul, is_div, op_signed, a_neg, b_neg;
  logic              div_zero, div_ovf;
  logic [DATA_W-1:0] a_mag, b_mag, short_res;

  always_comb begin
    is_mul    = (alu_op == OP_MUL) || (alu_op == OP_MULH) || (alu_op == OP_MULHU);
    is_div    = (alu_op == OP_DIV) || (alu_op == OP_DIVU) ||
                (alu_op == OP_REM) || (alu_op == OP_REMU);
    op_signed = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
    a_neg     = op_signed && alu_src0[DATA_W-1];
    b_neg     = op_signed && alu_src1[DATA_W-1];
    a_mag     = f_sign_fix(alu_src0, a_neg);
    b_mag     = f_sign_fix(alu_src1, b_neg);
    div_zero  = (alu_src1 == '0);
    div_ovf   = op_signed && (alu_src0 == MOST_NEG) && (alu_src1 == '1);
    short_res = '0;
    if (div_zero)
      short_res = ((alu_op == OP_DIV) || (alu_op == OP_DIVU)) ? '1 : alu_src0;
    else if (div_ovf)
      short_res = (alu_op == OP_DIV) ? MOST_NEG : '0;
  end

  // One shift-add multiply step and one restoring divide step
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   mul_hi_nx, mul_lo_nx, mul_res;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     div_sh, div_diff;
  logic [DATA_W-1:0]   div_rem_nx, div_quo_nx, div_res;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    mul_hi_nx = mul_sum[DATA_W:1];
    mul_lo_nx = {mul_sum[0], acc_lo[DATA_W-1:1]};
    prod      = f_sign_fix_wide({mul_hi_nx, mul_lo_nx}, neg_q);
    mul_res   = (op_q == OP_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];

    div_sh   = {acc_hi, acc_lo[DATA_W-1]};
    div_diff = div_sh - {1'b0, mcand};
    // A set top bit means the trial subtraction went negative: restore.
    if (div_diff[DATA_W]) begin
      div_rem_nx = div_sh[DATA_W-1:0];
      div_quo_nx = {acc_lo[DATA_W-2:0], 1'b0};
    end else begin
      div_rem_nx = div_diff[DATA_W-1:0];
      div_quo_nx = {acc_lo[DATA_W-2:0], 1'b1};
    end
    div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? f_sign_fix(div_quo_nx, neg_q)
                                                      : f_sign_fix(div_rem_nx, neg_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      cnt     <= '0;
      alu_res <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= alu_op;
            cnt  <= CNT_LAST;
            if (is_mul) begin
              acc_hi <= '0;
              acc_lo <= b_mag;
              mcand  <= a_mag;
              neg_q  <= a_neg ^ b_neg;
              state  <= S_MUL;
            end else if (is_div && (div_zero || div_ovf)) begin
              alu_res <= short_res;
              state   <= S_DONE;
            end else if (is_div) begin
              acc_hi <= '0;
              acc_lo <= a_mag;
              mcand  <= b_mag;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              state  <= S_DIV;
            end else begin
              alu_res <= f_alu(alu_op, alu_src0, alu_src1);
              state   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            alu_res <= mul_res;
            state   <= S_DONE;
          end
        end
        S_DIV: begin
          acc_hi <= div_rem_nx;
          acc_lo <= div_quo_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            alu_res <= div_res;
            state   <= S_DONE;
          end
        end
        default: begin
          if (out_ready)
            state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_iter.sv
module tb_alu_mdu_iter;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  alu_op;
  logic [31:0] alu_src0, alu_src1, alu_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mdu_iter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_res(alu_res), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, measure accept-to-out_valid latency, check result, take it.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int n;
    logic ready_leak;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_op = op; alu_src0 = a; alu_src1 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    ready_leak = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) ready_leak = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, alu_res, exp);
    if (lat > 1) check({tag, "_busy_ready"}, {31'b0, ready_leak}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] held;
  logic        seen_valid;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; alu_src0 = '0; alu_src1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_res", alu_res, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    // Single-cycle ops
    run_op("add_wrap", 5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run_op("sra",      5'b10000, 32'h80000000, 32'd4, 32'hF8000000, 1);
    run_op("slt",      5'b00100, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
    run_op("sltu",     5'b00101, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
    run_op("sub",      5'b00010, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    run_op("sll",      5'b01110, 32'h1, 32'd33, 32'h2, 1);
    run_op("xor",      5'b01011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    run_op("unknown",  5'b11111, 32'h12345678, 32'h9, 32'h0, 1);

    // Iterative multiply
    run_op("mul",   5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("mulhu", 5'b10101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh",  5'b10100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulh_mixed", 5'b10100, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33);

    // Iterative divide
    run_op("div",  5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem",  5'b11000, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu", 5'b10111, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 5'b11001, 32'd100, 32'd7, 32'd2, 33);

    // Shortcuts
    run_op("divu_zero", 5'b10111, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_zero",  5'b11000, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",   5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",   5'b11000, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

    // Backpressure
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'b00000; alu_src0 = 32'd10; alu_src1 = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    held = alu_res;
    check("bp_res", held, 32'd30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 4);
      alu_op = 5'b10001; alu_src0 = 32'hDEADBEEF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i == 4 || i == 9) begin
        check("bp_hold_res", alu_res, 32'd30);
        check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    check("bp_release_valid", {31'b0, out_valid}, 32'd0);

    // Flush during DIV, with a simultaneous in_valid that must be dropped
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'b10111; alu_src0 = 32'd100; alu_src1 = 32'd7;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; alu_op = 5'b00000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_ready", {31'b0, in_ready}, 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen_valid = 1'b1;
    end
    check("flush_no_output", {31'b0, seen_valid}, 32'd0);

    // Reset during DIV
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'b10110; alu_src0 = 32'hFFFFFFF9; alu_src1 = 32'd2;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_res", alu_res, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    run_op("add_after", 5'b00000, 32'd3, 32'd4, 32'd7, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
